// File: rtl/seg_pkg.sv
// Shared definitions for the countdown 7-segment display: scan states,
// segment encodings (active-low, {g,f,e,d,c,b,a}) and display geometry.
package seg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Index n holds the pattern for numeral n; element 9 is written first.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Bit 0 set marks a DIG state; bits [2:1] give the digit index.
  typedef enum logic [2:0] {
    BLANK0 = 3'd0,
    DIG0   = 3'd1,
    BLANK1 = 3'd2,
    DIG1   = 3'd3,
    BLANK2 = 3'd4,
    DIG2   = 3'd5,
    BLANK3 = 3'd6,
    DIG3   = 3'd7
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational decimal-digit to active-low 7-segment decoder; non-decimal
// codes produce a blank digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit < 4'd10) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/countdown_seg_display.sv
// Multiplexed 4-digit common-anode display of the 0..31 countdown value with
// blink-at-zero. Define LEAD_ZERO_BLANK_EN to blank a leading zero tens digit.
module countdown_seg_display
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [4:0]        countdown,
  input  logic              blink_en,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4:0]        s1_q, s2_q, disp_val_q, disp_val_d;
  logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  scan_state_e       state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [1:0]       tens;
  logic [3:0]       ones, digit_sel;
  logic [SEG_W-1:0] digit_seg;
  logic             is_dig, tick, blink_arm, blank_all;

  bcd_to_seg u_bcd_to_seg (
    .digit (digit_sel),
    .seg   (digit_seg)
  );

  always_comb begin
    disp_val_d = (s1_q == s2_q) ? s2_q : disp_val_q;

    if (disp_val_q >= 5'd30)      tens = 2'd3;
    else if (disp_val_q >= 5'd20) tens = 2'd2;
    else if (disp_val_q >= 5'd10) tens = 2'd1;
    else                          tens = 2'd0;
    ones = 4'(disp_val_q - 5'(10 * tens));

    // Refresh counter only runs during DIG states, so each DIG slot lasts
    // exactly REFRESH_DIV cycles and BLANK slots add one cycle on top.
    is_dig    = state_q[0];
    tick      = is_dig && (ref_cnt_q == RW'(REFRESH_DIV - 1));
    ref_cnt_d = (!is_dig || tick) ? '0 : ref_cnt_q + 1'b1;
    state_d   = (!is_dig || tick) ? scan_state_e'(state_q + 3'd1) : state_q;

    blink_arm     = (disp_val_q == 5'd0) && blink_en;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (blink_arm) begin
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) blink_phase_d = ~blink_phase_q;
      else                                   blink_cnt_d   = blink_cnt_q + 1'b1;
    end
    blank_all = blink_arm && blink_phase_q;

    // Outputs are derived from the next state so they register in step with it.
    digit_sel = (state_d == DIG1) ? {2'b00, tens} : ones;
    an_d      = '1;
    seg_d     = SEG_BLANK;
    if (state_d[0]) begin
      an_d[state_d[2:1]] = 1'b0;
      case (state_d)
        DIG0: seg_d = digit_seg;
`ifdef LEAD_ZERO_BLANK_EN
        DIG1: seg_d = (tens == 2'd0) ? SEG_BLANK : digit_seg;
`else
        DIG1: seg_d = digit_seg;
`endif
        default: seg_d = SEG_BLANK;
      endcase
      if (blank_all) seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      disp_val_q    <= '0;
      ref_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      state_q       <= BLANK0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      s1_q          <= countdown;
      s2_q          <= s1_q;
      disp_val_q    <= disp_val_d;
      ref_cnt_q     <= ref_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      state_q       <= state_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_countdown_seg_display.sv
// Scoreboard bench for countdown_seg_display with short refresh/blink periods.
module tb_countdown_seg_display;

  localparam int unsigned RD  = 4;
  localparam int unsigned BD  = 16;
  localparam int unsigned PER = (RD + 1) * 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] countdown = '0;
  logic       blink_en = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned k = 0;

  logic [10:0] exp_q[$];
  int          val_q[$];

  countdown_seg_display #(
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .countdown (countdown),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int unsigned seg_decode(input logic [6:0] s);
    for (int unsigned d = 0; d < 10; d++)
      if (seg_ref(d) == s) return d;
`ifdef LEAD_ZERO_BLANK_EN
    if (s == 7'h7F) return 0;
`endif
    return 15;
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned kk);
    int unsigned s, slot, pos;
    s = kk % PER;
    slot = s / (RD + 1);
    pos = s % (RD + 1);
    if (pos == 0) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned kk, input int unsigned v, input bit blink_on);
    int unsigned s, slot, pos;
    s = kk % PER;
    slot = s / (RD + 1);
    pos = s % (RD + 1);
    if (pos == 0 || slot >= 2) return 7'h7F;
    if (blink_on && v == 0 && kk >= 1 && (((kk - 1) / BD) % 2) == 1) return 7'h7F;
    if (slot == 0) return seg_ref(v % 10);
`ifdef LEAD_ZERO_BLANK_EN
    if (v / 10 == 0) return 7'h7F;
`endif
    return seg_ref(v / 10);
  endfunction

  task automatic step_clk();
    @(posedge clock);
    @(negedge clock);
    k++;
  endtask

  task automatic do_reset(input logic [4:0] v, input logic b);
    @(negedge clock);
    reset_n = 1'b0;
    countdown = v;
    blink_en = b;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;
  endtask

  task automatic check_frames(input string name, input int unsigned n, input int unsigned v, input bit blink_on);
    logic [10:0] e;
    for (int unsigned i = 1; i <= n; i++) exp_q.push_back({exp_an(k + i), exp_seg(k + i, v, blink_on)});
    for (int unsigned i = 0; i < n; i++) begin
      step_clk();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL %s k=%0d: got an=%b seg=%b, expected an=%b seg=%b", name, k, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_reset();
    bit found = 0;
    do_reset(5'd25, 1'b0);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    for (int unsigned i = 0; i < 3 * PER && !found; i++) begin
      if (an == 4'b1101) found = 1;
      else step_clk();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_dig1: got an=%b, expected an=1101 within budget", an);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      errors++;
      $display("FAIL async_reset: got an=%b seg=%b, expected an=1111 seg=1111111", an, seg);
    end
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    for (int unsigned i = 0; i <= PER; i++) begin
      checks++;
      if (an !== exp_an(k)) begin
        errors++;
        $display("FAIL post_reset_an k=%0d: got an=%b, expected an=%b", k, an, exp_an(k));
      end
      step_clk();
    end
  endtask

  task automatic test_value25();
    do_reset(5'd25, 1'b0);
    repeat (PER - 1) step_clk();
    check_frames("value25", 2 * PER, 25, 1'b0);
  endtask

  task automatic test_stability();
    do_reset(5'd12, 1'b0);
    repeat (5) step_clk();
    checks++;
    if (dut.disp_val_q !== 5'd12) begin
      errors++;
      $display("FAIL filter_settle: got disp_val=%0d, expected 12", dut.disp_val_q);
    end
    countdown = 5'd31;
    step_clk();
    countdown = 5'd12;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if (dut.disp_val_q !== 5'd12) begin
        errors++;
        $display("FAIL filter_glitch cycle %0d: got disp_val=%0d, expected 12", i, dut.disp_val_q);
      end
      step_clk();
    end
    countdown = 5'd11;
    val_q.push_back(12); val_q.push_back(12); val_q.push_back(11); val_q.push_back(11);
    for (int unsigned i = 1; i <= 4; i++) begin
      int e;
      step_clk();
      e = val_q.pop_front();
      checks++;
      if (int'(dut.disp_val_q) != e) begin
        errors++;
        $display("FAIL filter_latency edge %0d: got disp_val=%0d, expected %0d", i, dut.disp_val_q, e);
      end
    end
  endtask

  task automatic test_blink();
    do_reset(5'd0, 1'b1);
    check_frames("blink_on", 4 * BD, 0, 1'b1);
    blink_en = 1'b0;
    repeat (2) step_clk();
    check_frames("blink_off", 2 * PER, 0, 1'b0);
  endtask

  task automatic test_lead_zero();
    do_reset(5'd7, 1'b0);
    repeat (PER - 1) step_clk();
    check_frames("lead_zero", PER, 7, 1'b0);
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 0;
    for (int unsigned i = 0; i < 2 * PER && !ok; i++) begin
      if (an == target) ok = 1;
      else step_clk();
    end
  endtask

  task automatic test_sweep();
    bit ok0, ok1;
    int unsigned got_o, got_t;
    int e;
    do_reset(5'd0, 1'b0);
    for (int unsigned v = 0; v < 32; v++) begin
      countdown = 5'(v);
      val_q.push_back(int'((v / 10) * 16 + (v % 10)));
      repeat (4) step_clk();
      wait_an(4'b1110, ok0);
      got_o = seg_decode(seg);
      wait_an(4'b1101, ok1);
      got_t = seg_decode(seg);
      e = val_q.pop_front();
      checks++;
      if (!ok0 || !ok1 || int'(got_t * 16 + got_o) != e) begin
        errors++;
        $display("FAIL sweep value %0d: got tens=%0d ones=%0d (scan ok=%0d%0d), expected tens=%0d ones=%0d",
                 v, got_t, got_o, ok1, ok0, e / 16, e % 16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value25();
    test_stability();
    test_blink();
    test_lead_zero();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
